mem_pipe: RTL and testbench

Parametrised single-port memory model that succeeds the fixed 4×8 memory. It adds configurable data width, depth and read latency, byte-enable writes, and a valid/ready request and response handshake. Responses are buffered in a bounded FIFO, which gives flow control under backpressure. It sits behind the testbench interface as the DUT-side storage model for agent and sequence development.

---
 rtl/mem_pipe.sv | 143 ++++++++++++++
 tb/tb_mem_pipe.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/mem_pipe.sv
// mem_pipe: parametrised single-port memory with byte enables,
// a fixed-latency read pipeline and a credit-gated response FIFO.
module mem_pipe #(
  parameter int DW        = 8,
  parameter int DEPTH     = 4,
  parameter int AW        = $clog2(DEPTH),
  parameter int READ_LAT  = 1,
  parameter int RSP_DEPTH = 2,
  parameter logic [DW-1:0] INIT_VAL = {DW{1'b1}}
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  input  logic [DW/8-1:0] req_be,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err
);

  localparam int BW = DW / 8;
  localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CW = $clog2(RSP_DEPTH + 1);

  logic [DW-1:0] mem [DEPTH];
  logic          acc;
  logic          in_rng;
  logic          rd_acc;
  logic          wr_acc;
  logic [DW-1:0] rd_d;
  logic          rd_e;
  logic          push;
  logic [DW-1:0] push_d;
  logic          push_e;
  logic          pop;

  logic [DW-1:0] fd [RSP_DEPTH];
  logic [RSP_DEPTH-1:0] fe;
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  logic [CW-1:0] cnt;
  logic [CW-1:0] outstanding;

  assign acc    = req_valid & req_ready;
  assign in_rng = {1'b0, req_addr} < (AW+1)'(DEPTH);
  assign rd_acc = acc & ~req_we;
  assign wr_acc = acc & req_we & in_rng;
  assign rd_d   = in_rng ? mem[req_addr] : '0;
  assign rd_e   = ~in_rng;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= INIT_VAL;
    end else if (wr_acc) begin
      for (int b = 0; b < BW; b++)
        if (req_be[b]) mem[req_addr][8*b +: 8] <= req_wdata[8*b +: 8];
    end
  end

  // The FIFO write itself is the last latency stage, so only
  // READ_LAT-1 registers sit between accept and push.
  generate
    if (READ_LAT == 1) begin : g_nopipe
      assign push   = rd_acc;
      assign push_d = rd_d;
      assign push_e = rd_e;
    end else begin : g_pipe
      logic [READ_LAT-2:0] pv;
      logic [READ_LAT-2:0] pe;
      logic [DW-1:0]       pd [READ_LAT-1];

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          pv <= '0;
          pe <= '0;
          for (int i = 0; i < READ_LAT-1; i++) pd[i] <= '0;
        end else begin
          pv[0] <= rd_acc;
          pe[0] <= rd_e;
          pd[0] <= rd_d;
          for (int i = 1; i < READ_LAT-1; i++) begin
            pv[i] <= pv[i-1];
            pe[i] <= pe[i-1];
            pd[i] <= pd[i-1];
          end
        end
      end

      assign push   = pv[READ_LAT-2];
      assign push_d = pd[READ_LAT-2];
      assign push_e = pe[READ_LAT-2];
    end
  endgenerate

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(RSP_DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign rsp_valid = (cnt != '0);
  assign pop       = rsp_valid & rsp_ready;
  assign rsp_rdata = rsp_valid ? fd[rp] : '0;
  assign rsp_err   = rsp_valid & fe[rp];
  assign req_ready = outstanding < CW'(RSP_DEPTH);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
      fe  <= '0;
      for (int i = 0; i < RSP_DEPTH; i++) fd[i] <= '0;
    end else begin
      if (push) begin
        fd[wp] <= push_d;
        fe[wp] <= push_e;
        wp     <= nxt(wp);
      end
      if (pop) rp <= nxt(rp);
      unique case (1'b1)
        push & ~pop: cnt <= cnt + 1'b1;
        pop & ~push: cnt <= cnt - 1'b1;
        default:     cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      outstanding <= '0;
    end else begin
      unique case (1'b1)
        rd_acc & ~pop: outstanding <= outstanding + 1'b1;
        pop & ~rd_acc: outstanding <= outstanding - 1'b1;
        default:       outstanding <= outstanding;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_pipe.sv
// tb_mem_pipe: directed checks of mem_pipe with DW=32, DEPTH=5,
// READ_LAT=2, RSP_DEPTH=2.
module tb_mem_pipe;

  localparam int DW = 32;
  localparam int DEPTH = 5;
  localparam int AW = 3;
  localparam int LAT = 2;
  localparam logic [31:0] INIT = 32'hFFFF_FFFF;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [3:0]    req_be = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;

  int nchk = 0;
  int nerr = 0;

  mem_pipe #(
    .DW(DW), .DEPTH(DEPTH), .AW(AW),
    .READ_LAT(LAT), .RSP_DEPTH(2)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [AW-1:0] a,
                       input logic [31:0] d, input logic [3:0] be);
    int n = 0;
    req_valid = 1'b1;
    req_we = we;
    req_addr = a;
    req_wdata = d;
    req_be = be;
    while (!req_ready && n < 20) begin
      tick;
      n++;
    end
    if (!req_ready) chk("req_ready_timeout", 0, 1);
    tick;
    req_valid = 1'b0;
    req_we = 1'b0;
  endtask

  task automatic rd_chk(input logic [AW-1:0] a,
                        input logic [31:0] exp,
                        input logic experr);
    int n;
    issue(1'b0, a, 32'h0, 4'h0);
    n = 1;
    while (!rsp_valid && n < 20) begin
      tick;
      n++;
    end
    chk("rd_lat", 64'(n), 64'(LAT));
    chk("rd_data", rsp_rdata, exp);
    chk("rd_err", rsp_err, experr);
    tick;
  endtask

  logic [AW-1:0] ba [4] = '{3'd0, 3'd2, 3'd3, 3'd4};
  logic [31:0]   bx [4] = '{32'hFFFF_FFFF, 32'h11BB_33DD,
                            32'h0000_003C, 32'hFFFF_FFFF};
  logic [31:0]   oor [5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF,
                             32'h11BB_33DD, 32'h0000_003C,
                             32'hFFFF_FFFF};

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int got;
    logic seen;

    #2;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_err", rsp_err, 0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < DEPTH; i++) rd_chk(AW'(i), INIT, 1'b0);

    issue(1'b1, 3'd2, 32'h1122_3344, 4'b1111);
    issue(1'b1, 3'd2, 32'hAABB_CCDD, 4'b0101);
    rd_chk(3'd2, 32'h11BB_33DD, 1'b0);

    issue(1'b1, 3'd3, 32'h0000_003C, 4'b1111);
    rd_chk(3'd3, 32'h0000_003C, 1'b0);

    issue(1'b1, 3'd6, 32'hDEAD_BEEF, 4'b1111);
    rd_chk(3'd6, 32'h0, 1'b1);
    for (int i = 0; i < DEPTH; i++) rd_chk(AW'(i), oor[i], 1'b0);

    rsp_ready = 1'b0;
    acc = 0;
    req_valid = 1'b1;
    req_we = 1'b0;
    req_addr = ba[0];
    for (int c = 0; c < 5; c++) begin
      chk("bp_ready", req_ready, 64'(c < 2));
      if (req_ready) acc++;
      tick;
      req_addr = ba[acc < 4 ? acc : 3];
    end
    chk("bp_accepts", 64'(acc), 2);
    chk("bp_valid", rsp_valid, 1);
    rsp_ready = 1'b1;
    chk("bp_no_comb_ready", req_ready, 0);
    got = 0;
    for (int it = 0; it < 30 && got < 4; it++) begin
      if (rsp_valid) begin
        chk("bp_order", rsp_rdata, bx[got]);
        got++;
      end
      if (req_valid && req_ready) acc++;
      tick;
      if (it == 0) chk("bp_ready_rise", req_ready, 1);
      req_valid = (acc < 4);
      req_addr = ba[acc < 4 ? acc : 3];
    end
    chk("bp_count", 64'(got), 4);
    req_valid = 1'b0;
    tick;

    rsp_ready = 1'b0;
    issue(1'b0, 3'd0, 32'h0, 4'h0);
    issue(1'b1, 3'd1, 32'h0000_005A, 4'b1111);
    issue(1'b0, 3'd1, 32'h0, 4'h0);
    chk("pre_rst_ready", req_ready, 0);
    chk("pre_rst_valid", rsp_valid, 1);
    #3;
    rst = 1'b0;
    #1;
    chk("mid_rst_ready", req_ready, 1);
    chk("mid_rst_valid", rsp_valid, 0);
    chk("mid_rst_rdata", rsp_rdata, 0);
    chk("mid_rst_err", rsp_err, 0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    rsp_ready = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick;
      seen = seen | rsp_valid;
    end
    chk("no_stale_rsp", seen, 0);
    rd_chk(3'd1, INIT, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors",
             nchk, nerr);
    $finish;
  end

endmodule
